// File: rtl/spart_pkg.sv
// Shared constants and types for the spart bus-side scheduler:
// register addresses, FSM state encoding and default baud divisors.
package spart_pkg;

    localparam logic [1:0] ADDR_BUF  = 2'b00;
    localparam logic [1:0] ADDR_STAT = 2'b01;
    localparam logic [1:0] ADDR_DBL  = 2'b10;
    localparam logic [1:0] ADDR_DBH  = 2'b11;

    localparam logic [15:0] DEF_DIV0 = 16'h028A;
    localparam logic [15:0] DEF_DIV1 = 16'h0145;
    localparam logic [15:0] DEF_DIV2 = 16'h00A2;
    localparam logic [15:0] DEF_DIV3 = 16'h0050;

    typedef enum logic [2:0] {
        CFG_LO,
        CFG_HI,
        IDLE,
        TX_WR,
        RX_RD,
        GAP
    } state_e;

    typedef enum logic {
        RR_TX = 1'b0,
        RR_RX = 1'b1
    } rr_e;

    function automatic logic [15:0] pick_div(
        input logic [1:0]  sel,
        input logic [15:0] d0,
        input logic [15:0] d1,
        input logic [15:0] d2,
        input logic [15:0] d3
    );
        case (sel)
            2'b00:   return d0;
            2'b01:   return d1;
            2'b10:   return d2;
            default: return d3;
        endcase
    endfunction

endpackage

// File: rtl/spart_rr_arb.sv
// Two-requester round-robin arbiter: combinational grant, registered
// record of which side was served last.
module spart_rr_arb
    import spart_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic tx_req,
    input  logic rx_req,
    output logic tx_gnt,
    output logic rx_gnt
);

    rr_e rr_last_reg;

    // On contention the side that was not served last wins.
    always_comb begin
        tx_gnt = tx_req & (~rx_req | (rr_last_reg == RR_RX));
        rx_gnt = rx_req & (~tx_req | (rr_last_reg == RR_TX));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_last_reg <= RR_RX;
        end else if (tx_gnt) begin
            rr_last_reg <= RR_TX;
        end else if (rx_gnt) begin
            rr_last_reg <= RR_RX;
        end
    end

endmodule

// File: rtl/spart_io_sched.sv
// Bus-side controller for the spart: programs the baud divisor, then
// schedules single-cycle TX writes and RX reads with a GAP after each access.
module spart_io_sched
    import spart_pkg::*;
#(
    parameter logic [15:0] DIV0 = DEF_DIV0,
    parameter logic [15:0] DIV1 = DEF_DIV1,
    parameter logic [15:0] DIV2 = DEF_DIV2,
    parameter logic [15:0] DIV3 = DEF_DIV3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] br_cfg,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    input  logic       rx_ready,
    output logic       cfg_done,
    output logic       iocs,
    output logic       iorw,
    output logic [1:0] ioaddr,
    inout  wire  [7:0] databus,
    input  logic       rda,
    input  logic       tbr
);

    state_e     state_reg, state_next;
    logic [1:0] br_q_reg;
    logic [7:0] wr_q_reg;
    logic       rx_valid_reg;
    logic [7:0] rx_data_reg;
    logic       cfg_done_reg;

    logic       cfg_stale;
    logic       tx_req, rx_req, tx_gnt, rx_gnt;
    logic       bus_cs, bus_rw, bus_en, tx_ready_c;
    logic [1:0] bus_addr;
    logic [7:0] bus_dout;
    logic [15:0] div_live, div_held;

    assign cfg_stale = (br_cfg != br_q_reg);
    assign div_live  = pick_div(br_cfg,   DIV0, DIV1, DIV2, DIV3);
    assign div_held  = pick_div(br_q_reg, DIV0, DIV1, DIV2, DIV3);

    // Requests exist only in an IDLE cycle that is not preempted by a reprogram.
    assign tx_req = (state_reg == IDLE) & ~cfg_stale & tx_valid & tbr;
    assign rx_req = (state_reg == IDLE) & ~cfg_stale & rda & ~rx_valid_reg;

    spart_rr_arb u_arb (
        .clk    (clk),
        .rst    (rst),
        .tx_req (tx_req),
        .rx_req (rx_req),
        .tx_gnt (tx_gnt),
        .rx_gnt (rx_gnt)
    );

    always_comb begin
        state_next = state_reg;
        bus_cs     = 1'b0;
        bus_rw     = 1'b1;
        bus_addr   = ADDR_BUF;
        bus_en     = 1'b0;
        bus_dout   = 8'h00;
        tx_ready_c = 1'b0;
        case (state_reg)
            CFG_LO: begin
                bus_cs     = 1'b1;
                bus_rw     = 1'b0;
                bus_addr   = ADDR_DBL;
                bus_en     = 1'b1;
                bus_dout   = div_live[7:0];
                state_next = CFG_HI;
            end
            CFG_HI: begin
                bus_cs     = 1'b1;
                bus_rw     = 1'b0;
                bus_addr   = ADDR_DBH;
                bus_en     = 1'b1;
                bus_dout   = div_held[15:8];
                state_next = GAP;
            end
            IDLE: begin
                if (cfg_stale) begin
                    state_next = CFG_LO;
                end else if (tx_gnt) begin
                    tx_ready_c = 1'b1;
                    state_next = TX_WR;
                end else if (rx_gnt) begin
                    state_next = RX_RD;
                end
            end
            TX_WR: begin
                bus_cs     = 1'b1;
                bus_rw     = 1'b0;
                bus_en     = 1'b1;
                bus_dout   = wr_q_reg;
                state_next = GAP;
            end
            RX_RD: begin
                bus_cs     = 1'b1;
                state_next = GAP;
            end
            GAP:     state_next = IDLE;
            default: state_next = CFG_LO;
        endcase
    end

    // Bus outputs are gated by reset so they idle without waiting for a clock edge.
    assign iocs     = rst & bus_cs;
    assign iorw     = ~rst | bus_rw;
    assign ioaddr   = rst ? bus_addr : ADDR_BUF;
    assign databus  = (rst & bus_en) ? bus_dout : 8'hzz;
    assign tx_ready = rst & tx_ready_c;
    assign rx_valid = rx_valid_reg;
    assign rx_data  = rx_data_reg;
    assign cfg_done = cfg_done_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= CFG_LO;
            br_q_reg     <= 2'b00;
            wr_q_reg     <= 8'h00;
            rx_valid_reg <= 1'b0;
            rx_data_reg  <= 8'h00;
            cfg_done_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == CFG_LO) begin
                br_q_reg <= br_cfg;
            end
            if (state_reg == CFG_HI) begin
                cfg_done_reg <= 1'b1;
            end else if ((state_reg == IDLE) && cfg_stale) begin
                cfg_done_reg <= 1'b0;
            end
            if (tx_gnt) begin
                wr_q_reg <= tx_data;
            end
            // A capture never coincides with a consume since reads need ~rx_valid.
            if (state_reg == RX_RD) begin
                rx_data_reg  <= databus;
                rx_valid_reg <= 1'b1;
            end else if (rx_valid_reg && rx_ready) begin
                rx_valid_reg <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spart_io_sched.sv
// Directed bench for spart_io_sched with a tiny spart model that returns
// sp_byte on buffer reads.
module tb_spart_io_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] br_cfg;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       cfg_done;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    wire  [7:0] databus;
    logic       rda;
    logic       tbr;
    logic [7:0] sp_byte;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    assign databus = (iocs && iorw && (ioaddr == 2'b00)) ? sp_byte : 8'hzz;

    spart_io_sched dut (
        .clk      (clk),
        .rst      (rst),
        .br_cfg   (br_cfg),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_ready (rx_ready),
        .cfg_done (cfg_done),
        .iocs     (iocs),
        .iorw     (iorw),
        .ioaddr   (ioaddr),
        .databus  (databus),
        .rda      (rda),
        .tbr      (tbr)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("vec %0d %s observed %h expected %h", vectors, tag, obs, exp);
    endtask

    task automatic nxt();
        @(negedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; br_cfg = 2'b11; tx_valid = 1'b0; tx_data = 8'h00;
        rx_ready = 1'b0; rda = 1'b0; tbr = 1'b0; sp_byte = 8'h00;
        #3 rst = 1'b0;
        nxt(); nxt();
        chk("rst_iocs",     {15'd0, iocs},     16'd0);
        chk("rst_iorw",     {15'd0, iorw},     16'd1);
        chk("rst_ioaddr",   {14'd0, ioaddr},   16'd0);
        chk("rst_tx_ready", {15'd0, tx_ready}, 16'd0);
        chk("rst_rx_valid", {15'd0, rx_valid}, 16'd0);
        chk("rst_rx_data",  {8'd0, rx_data},   16'h0000);
        chk("rst_cfg_done", {15'd0, cfg_done}, 16'd0);

        // Divisor programming for br_cfg=11 after release.
        rst = 1'b1; #1;
        chk("cfg_lo_bus", {12'd0, iocs, iorw, ioaddr}, 16'b1010);
        chk("cfg_lo_db",  {8'd0, databus}, 16'h0050);
        nxt();
        chk("cfg_hi_bus", {12'd0, iocs, iorw, ioaddr}, 16'b1011);
        chk("cfg_hi_db",  {8'd0, databus}, 16'h0000);
        chk("cfg_hi_done", {15'd0, cfg_done}, 16'd0);
        nxt();
        chk("cfg_gap_iocs", {15'd0, iocs}, 16'd0);
        chk("cfg_gap_done", {15'd0, cfg_done}, 16'd1);
        nxt();

        // Single TX transfer.
        tx_valid = 1'b1; tx_data = 8'hA5; tbr = 1'b1; #1;
        chk("tx_grant_ready", {15'd0, tx_ready}, 16'd1);
        nxt();
        tx_valid = 1'b0; #1;
        chk("tx_wr_ready", {15'd0, tx_ready}, 16'd0);
        chk("tx_wr_bus", {12'd0, iocs, iorw, ioaddr}, 16'b1000);
        chk("tx_wr_db",  {8'd0, databus}, 16'h00A5);
        nxt();
        chk("tx_gap_iocs", {15'd0, iocs}, 16'd0);
        nxt();

        // Single RX transfer followed by backpressure.
        sp_byte = 8'h3C; rda = 1'b1; #1;
        chk("rx_idle_iocs", {15'd0, iocs}, 16'd0);
        nxt();
        chk("rx_rd_bus", {12'd0, iocs, iorw, ioaddr}, 16'b1100);
        chk("rx_rd_valid", {15'd0, rx_valid}, 16'd0);
        nxt();
        chk("rx_gap_valid", {15'd0, rx_valid}, 16'd1);
        chk("rx_gap_data",  {8'd0, rx_data}, 16'h003C);
        chk("rx_gap_iocs",  {15'd0, iocs}, 16'd0);
        nxt();
        nxt();
        chk("rx_stall1_iocs", {15'd0, iocs}, 16'd0);
        nxt();
        chk("rx_stall2_iocs", {15'd0, iocs}, 16'd0);
        rx_ready = 1'b1;
        nxt();
        rx_ready = 1'b0; sp_byte = 8'h77; #1;
        chk("rx_consumed_valid", {15'd0, rx_valid}, 16'd0);
        chk("rx_consumed_data",  {8'd0, rx_data}, 16'h003C);
        chk("rx_consumed_iocs",  {15'd0, iocs}, 16'd0);
        nxt();
        chk("rx2_rd_bus", {12'd0, iocs, iorw, ioaddr}, 16'b1100);
        nxt();
        chk("rx2_valid", {15'd0, rx_valid}, 16'd1);
        chk("rx2_data",  {8'd0, rx_data}, 16'h0077);
        nxt();

        // Both sides eligible: TX first, then strict alternation.
        rx_ready = 1'b1; tx_valid = 1'b1; tbr = 1'b1; rda = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tx_data = 8'h10 + 8'(i);
            sp_byte = 8'h80 + 8'(i);
            #1;
            chk($sformatf("alt%0d_tx_ready", i), {15'd0, tx_ready}, (i % 2 == 0) ? 16'd1 : 16'd0);
            nxt();
            chk($sformatf("alt%0d_bus", i), {12'd0, iocs, iorw, ioaddr},
                (i % 2 == 0) ? 16'b1000 : 16'b1100);
            if (i % 2 == 0) chk($sformatf("alt%0d_db", i), {8'd0, databus}, 16'h0010 + 16'(i));
            nxt();
            chk($sformatf("alt%0d_gap_iocs", i), {15'd0, iocs}, 16'd0);
            if (i % 2 == 1) chk($sformatf("alt%0d_rx_data", i), {8'd0, rx_data}, 16'h0080 + 16'(i));
            nxt();
        end
        tx_valid = 1'b0; rda = 1'b0; rx_ready = 1'b0;

        // br_cfg changes during a read: read completes, then reprogram.
        rda = 1'b1; sp_byte = 8'hC3;
        nxt();
        br_cfg = 2'b01; #1;
        chk("brc_rd_bus", {12'd0, iocs, iorw, ioaddr}, 16'b1100);
        nxt();
        rda = 1'b0;
        chk("brc_rx_valid", {15'd0, rx_valid}, 16'd1);
        chk("brc_rx_data",  {8'd0, rx_data}, 16'h00C3);
        chk("brc_gap_done", {15'd0, cfg_done}, 16'd1);
        nxt();
        tx_valid = 1'b1; tx_data = 8'h5A; tbr = 1'b1; #1;
        chk("brc_idle_ready", {15'd0, tx_ready}, 16'd0);
        chk("brc_idle_iocs",  {15'd0, iocs}, 16'd0);
        nxt();
        chk("brc_lo_done", {15'd0, cfg_done}, 16'd0);
        chk("brc_lo_bus",  {12'd0, iocs, iorw, ioaddr}, 16'b1010);
        chk("brc_lo_db",   {8'd0, databus}, 16'h0045);
        nxt();
        chk("brc_hi_bus",  {12'd0, iocs, iorw, ioaddr}, 16'b1011);
        chk("brc_hi_db",   {8'd0, databus}, 16'h0001);
        nxt();
        chk("brc_gap_iocs", {15'd0, iocs}, 16'd0);
        chk("brc_gap_done2", {15'd0, cfg_done}, 16'd1);
        nxt();
        chk("brc_tx_ready", {15'd0, tx_ready}, 16'd1);
        nxt();
        tx_valid = 1'b0;
        chk("brc_tx_bus", {12'd0, iocs, iorw, ioaddr}, 16'b1000);
        chk("brc_tx_db",  {8'd0, databus}, 16'h005A);

        // Reset mid-access: outputs idle immediately, no clock edge needed.
        rst = 1'b0; #1;
        chk("arst_iocs",     {15'd0, iocs}, 16'd0);
        chk("arst_iorw",     {15'd0, iorw}, 16'd1);
        chk("arst_ioaddr",   {14'd0, ioaddr}, 16'd0);
        chk("arst_cfg_done", {15'd0, cfg_done}, 16'd0);
        chk("arst_rx_valid", {15'd0, rx_valid}, 16'd0);
        chk("arst_rx_data",  {8'd0, rx_data}, 16'h0000);
        nxt(); nxt();
        rst = 1'b1; #1;
        chk("rerun_lo_bus", {12'd0, iocs, iorw, ioaddr}, 16'b1010);
        chk("rerun_lo_db",  {8'd0, databus}, 16'h0045);
        nxt();
        chk("rerun_hi_bus", {12'd0, iocs, iorw, ioaddr}, 16'b1011);
        chk("rerun_hi_db",  {8'd0, databus}, 16'h0001);
        nxt();
        chk("rerun_done", {15'd0, cfg_done}, 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
